// File: rtl/morse_pkg.sv
// Shared types and letter tables for the Morse serialiser.
package morse_pkg;

  localparam int unsigned NUM_LETTERS = 26;
  localparam int unsigned MAX_LEN     = 13;
  localparam int unsigned LEN_W       = 4;
  localparam int unsigned LETTER_W    = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } state_e;

  // Unit patterns, right-aligned: dot = 1, dash = 111, intra-letter gap = 0.
  localparam logic [MAX_LEN-1:0] PAT_TBL [NUM_LETTERS] = '{
    13'b0000000010111,  // A .-
    13'b0000111010101,  // B -...
    13'b0011101011101,  // C -.-.
    13'b0000001110101,  // D -..
    13'b0000000000001,  // E .
    13'b0000101011101,  // F ..-.
    13'b0000111011101,  // G --.
    13'b0000001010101,  // H ....
    13'b0000000000101,  // I ..
    13'b1011101110111,  // J .---
    13'b0000111010111,  // K -.-
    13'b0000101110101,  // L .-..
    13'b0000001110111,  // M --
    13'b0000000011101,  // N -.
    13'b0011101110111,  // O ---
    13'b0010111011101,  // P .--.
    13'b1110111010111,  // Q --.-
    13'b0000001011101,  // R .-.
    13'b0000000010101,  // S ...
    13'b0000000000111,  // T -
    13'b0000001010111,  // U ..-
    13'b0000101010111,  // V ...-
    13'b0000101110111,  // W .--
    13'b0011101010111,  // X -..-
    13'b1110101110111,  // Y -.--
    13'b0011101110101   // Z --..
  };

  // Pattern length in units for each letter.
  localparam logic [LEN_W-1:0] LEN_TBL [NUM_LETTERS] = '{
    4'd5,  4'd9,  4'd11, 4'd7,  4'd1,  4'd9,  4'd9,  4'd7,  4'd3,
    4'd13, 4'd9,  4'd9,  4'd7,  4'd5,  4'd11, 4'd11, 4'd13, 4'd7,
    4'd5,  4'd3,  4'd7,  4'd9,  4'd9,  4'd11, 4'd13, 4'd11
  };

endpackage

// File: rtl/morse_lut.sv
// Letter code to left-aligned unit pattern, length and validity.
module morse_lut
  import morse_pkg::*;
#(
  parameter int unsigned PAT_W = 16
) (
  input  logic [LETTER_W-1:0] letter,
  output logic [PAT_W-1:0]    pattern_c,
  output logic [LEN_W-1:0]    len_c,
  output logic                valid_c
);

  localparam int unsigned SH_W = $clog2(PAT_W + 1);

  logic [LETTER_W-1:0] idx;
  logic [MAX_LEN-1:0]  raw;

  // Table lookup; invalid codes map to an empty pattern.
  always_comb begin
    valid_c   = (letter < LETTER_W'(NUM_LETTERS));
    idx       = valid_c ? letter : '0;
    raw       = PAT_TBL[idx];
    len_c     = valid_c ? LEN_TBL[idx] : '0;
    pattern_c = '0;
    if (valid_c) begin
      pattern_c = PAT_W'(raw) << (SH_W'(PAT_W) - SH_W'(len_c));
    end
  end

endmodule

// File: rtl/morse_shifter.sv
// Serialises one Morse letter, one unit per divider tick.
// Optional trailing letter gap: define MORSE_LETTER_GAP_EN.
module morse_shifter
  import morse_pkg::*;
#(
  parameter int unsigned PAT_W = 16
`ifdef MORSE_LETTER_GAP_EN
  ,
  parameter int unsigned GAP_UNITS = 3
`endif
) (
  input  logic                clock_in,
  input  logic                clear_b,
  input  logic [LETTER_W-1:0] letter,
  input  logic                start,
  input  logic                tick,
  output logic                morse_out,
  output logic                busy,
  output logic                done
);

  logic [PAT_W-1:0] lut_pattern;
  logic [LEN_W-1:0] lut_len;
  logic             lut_valid;

  state_e           state_q, state_d;
  logic [PAT_W-1:0] sr_q, sr_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             morse_out_q, morse_out_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             run_q, run_d;

  morse_lut #(
    .PAT_W (PAT_W)
  ) u_lut (
    .letter    (letter),
    .pattern_c (lut_pattern),
    .len_c     (lut_len),
    .valid_c   (lut_valid)
  );

  // Reset release synchroniser: loads are blocked until one edge after release.
  always_comb run_d = 1'b1;

  // Release-sync register.
  always_ff @(posedge clock_in or negedge clear_b) begin
    if (!clear_b) run_q <= 1'b0;
    else          run_q <= run_d;
  end

  // Next-state, datapath and registered-output computation.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      IDLE: begin
        if (run_q && start && lut_valid) begin
          sr_d    = lut_pattern;
          cnt_d   = lut_len;
          state_d = SEND;
        end
      end
      SEND: begin
        if (tick) begin
          if (cnt_q > 4'd1) begin
            sr_d  = sr_q << 1;
            cnt_d = cnt_q - 4'd1;
          end else begin
            sr_d = '0;
`ifdef MORSE_LETTER_GAP_EN
            cnt_d   = LEN_W'(GAP_UNITS);
            state_d = GAP;
`else
            cnt_d   = '0;
            state_d = DONE;
`endif
          end
        end
      end
      GAP: begin
`ifdef MORSE_LETTER_GAP_EN
        if (tick) begin
          if (cnt_q > 4'd1) begin
            cnt_d = cnt_q - 4'd1;
          end else begin
            cnt_d   = '0;
            state_d = DONE;
          end
        end
`else
        state_d = IDLE;
`endif
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs follow the next state so they change on the same edge.
    morse_out_d = (state_d == SEND) && sr_d[PAT_W-1];
    busy_d      = (state_d != IDLE);
    done_d      = (state_d == DONE);
  end

  // State, datapath and output registers.
  always_ff @(posedge clock_in or negedge clear_b) begin
    if (!clear_b) begin
      state_q     <= IDLE;
      sr_q        <= '0;
      cnt_q       <= '0;
      morse_out_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      cnt_q       <= cnt_d;
      morse_out_q <= morse_out_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign morse_out = morse_out_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_morse_shifter.sv
// Directed bench for morse_shifter with a unit-level scoreboard.
module tb_morse_shifter;

  logic       clk;
  logic       clear_b;
  logic [4:0] letter;
  logic       start;
  logic       tick;
  logic       morse_out;
  logic       busy;
  logic       done;

  int n_tests = 0;
  int n_fail  = 0;

  logic exp_q[$];
  logic cur;

  // Independent reference: dot/dash strings per letter.
  string codes [26] = '{
    ".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..",
    ".---", "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.",
    "...", "-", "..-", "...-", ".--", "-..-", "-.--", "--.."
  };

  morse_shifter dut (
    .clock_in  (clk),
    .clear_b   (clear_b),
    .letter    (letter),
    .start     (start),
    .tick      (tick),
    .morse_out (morse_out),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, required finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic obs, input logic exp_v);
    n_tests++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp_v);
    end
  endtask

  // Push the expected unit stream for one letter; returns the tick count.
  task automatic push_letter(input int l, output int total);
    string s;
    int    n0;
    s  = codes[l];
    n0 = exp_q.size();
    for (int i = 0; i < s.len(); i++) begin
      if (i > 0) exp_q.push_back(1'b0);
      if (s[i] == "-") begin
        exp_q.push_back(1'b1);
        exp_q.push_back(1'b1);
        exp_q.push_back(1'b1);
      end else begin
        exp_q.push_back(1'b1);
      end
    end
`ifdef MORSE_LETTER_GAP_EN
    for (int i = 0; i < 3; i++) exp_q.push_back(1'b0);
`endif
    total = exp_q.size() - n0;
  endtask

  // Send one letter from the current negedge; ticks every per cycles.
  task automatic send(input logic [4:0] l, input int per, input bit tick_on_start,
                      input int intrude_unit);
    int total;
    push_letter(int'(l), total);
    start  = 1'b1;
    letter = l;
    tick   = tick_on_start;
    @(negedge clk);
    start = 1'b0;
    tick  = 1'b0;
    chk("busy_at_load", busy, 1'b1);
    chk("done_at_load", done, 1'b0);
    cur = exp_q.pop_front();
    chk("unit_first", morse_out, cur);
    for (int j = 1; j <= total; j++) begin
      for (int c = 0; c < per - 1; c++) begin
        if (j == intrude_unit && c == 0) begin
          start  = 1'b1;
          letter = 5'd4;
        end
        @(negedge clk);
        start = 1'b0;
        chk("unit_hold", morse_out, cur);
        chk("busy_hold", busy, 1'b1);
      end
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
      if (j < total) begin
        cur = exp_q.pop_front();
        chk("unit_after_tick", morse_out, cur);
        chk("no_early_done", done, 1'b0);
      end else begin
        chk("done_pulse", done, 1'b1);
        chk("out_low_done", morse_out, 1'b0);
        chk("busy_in_done", busy, 1'b1);
      end
    end
    @(negedge clk);
    chk("done_one_cycle", done, 1'b0);
    chk("busy_fall", busy, 1'b0);
    chk("out_idle", morse_out, 1'b0);
  endtask

  initial begin
    clear_b = 1'b0;
    start   = 1'b0;
    tick    = 1'b0;
    letter  = 5'd0;
    repeat (2) @(negedge clk);
    chk("rst_out", morse_out, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    clear_b = 1'b1;
    repeat (3) @(negedge clk);

    // A, E, T with regular ticks.
    send(5'd0, 4, 1'b0, -1);
    send(5'd4, 4, 1'b0, -1);
    send(5'd19, 3, 1'b0, -1);

    // Invalid code: nothing happens.
    start  = 1'b1;
    letter = 5'd27;
    tick   = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      start = 1'b0;
      chk("inv_busy", busy, 1'b0);
      chk("inv_out", morse_out, 1'b0);
      chk("inv_done", done, 1'b0);
    end
    tick = 1'b0;
    @(negedge clk);

    // J with a start for E during unit 5; E must not follow.
    send(5'd9, 2, 1'b0, 5);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("no_queued_busy", busy, 1'b0);
    end

    // J interrupted by async reset during unit 7.
    start  = 1'b1;
    letter = 5'd9;
    @(negedge clk);
    start = 1'b0;
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
    end
    chk("j7_busy", busy, 1'b1);
    chk("j7_out", morse_out, 1'b1);
    @(posedge clk);
    #2 clear_b = 1'b0;
    #1;
    chk("async_rst_out", morse_out, 1'b0);
    chk("async_rst_busy", busy, 1'b0);
    chk("async_rst_done", done, 1'b0);

    // Release with a start at the first edge: ignored by the synchroniser.
    @(negedge clk);
    clear_b = 1'b1;
    start   = 1'b1;
    letter  = 5'd4;
    @(negedge clk);
    start = 1'b0;
    chk("sync_first_edge", busy, 1'b0);

    // Load on the second edge, with a coincident tick that must be ignored.
    send(5'd0, 4, 1'b1, -1);

    n_tests++;
    assert (exp_q.size() == 0) else begin
      n_fail++;
      $error("FAIL scoreboard_empty: observed %0d left expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/morse_shifter.md
# morse_shifter

Serialises one Morse letter onto a single output line, one symbol unit per tick from the upstream rate divider. A letter code and start pulse load a unit pattern; each divider tick shifts one unit out, so dot = 1 unit high, dash = 3 units high, intra-letter gap = 1 unit low. The block sits directly downstream of the rate divider, consuming its one-cycle `clock_out` pulse as `tick`, and drives the LED/output pin.

## Interface
- `PAT_W`, 16: pattern register width in units; must be ≥ 13 (longest letter).
- `GAP_UNITS`, 3: low units appended after a letter when the gap feature is compiled in.
- `clock_in`  input  1  system clock; all state changes on its rising edge.
- `clear_b`  input  1  reset; asynchronous, active-low.
- `letter`  input  5  letter code, 0 = A … 25 = Z. Codes 26–31 are invalid.
- `start`  input  1  one-cycle request to send `letter`.
- `tick`  input  1  one-cycle unit strobe from the rate divider.
- `morse_out`  output  1  serial Morse level.
- `busy`  output  1  high from load until the return to IDLE.
- `done`  output  1  one-cycle pulse when a letter completes.

## Operation
- States: IDLE, SEND, GAP, DONE.
- IDLE: if `start`=1 and `letter`<26:
  - load `sr` with the pattern left-aligned (first unit in bit PAT_W-1).
  - load `cnt` with the pattern length (1..13).
  - go to SEND.
- IDLE with `start` and an invalid letter: no effect. The block stays in IDLE and `busy` stays 0.
- Pattern encoding, MSB first:
  - E = `1`, len 1.
  - T = `111`, len 3.
  - A = `10111`, len 5.
  - N = `11101`, len 5.
  - J = `1011101110111`, len 13.
  - No trailing zero in any pattern.
- SEND, `morse_out` = `sr[PAT_W-1]`. On `tick`:
  - if `cnt`>1: `sr` ← `sr`<<1 (zero fill), `cnt` ← `cnt`-1.
  - if `cnt`=1: go to GAP with `cnt` ← GAP_UNITS, or go straight to DONE when the gap feature is absent.
- GAP: `morse_out`=0. On `tick`, decrement `cnt`; when it reaches 1 and `tick` arrives, go to DONE.
- DONE: `done`=1 for exactly one cycle, `morse_out`=0, then IDLE.
- `start` outside IDLE is ignored; it is not queued.
- `tick` in IDLE or DONE is ignored.
- `tick` in the same cycle as a load is ignored.
- Arithmetic: `cnt` is 4 bits, unsigned. No wrap is possible because decrement happens only while `cnt`>1.

## Timing
- Reset (`clear_b`=0, any time, including mid-letter): next state is IDLE; `sr`=0, `cnt`=0, `morse_out`=0, `busy`=0, `done`=0.
- Release of `clear_b` is synchronised internally; the first load is accepted on the second rising edge after release.
- Load latency: `start` is sampled at edge N. From edge N onward, `busy`=1 and `morse_out` = first unit.
- Unit duration: each unit lasts from one accepted `tick` edge to the next. The first unit's length depends on the divider phase (0..D cycles) and is accepted as is.
- Total letter time: len + GAP_UNITS ticks (or len ticks without the gap), plus 1 cycle for DONE.
- `busy` falls on the same edge that `done` falls.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- `MORSE_LETTER_GAP_EN` defined: SEND → GAP, and GAP_UNITS low units follow each letter before `done`.
- Not defined: the GAP state, its logic and the GAP_UNITS parameter usage are removed. SEND → DONE on the last unit's tick, and `done` fires GAP_UNITS ticks earlier.

## Structure
- Package `morse_pkg`:
  - state enum (IDLE/SEND/GAP/DONE).
  - `NUM_LETTERS`=26, `MAX_LEN`=13.
  - 26-entry pattern and length constant tables.
- Sub-module `morse_lut`: combinational `letter` → {pattern[PAT_W-1:0], len[3:0], valid}. The FSM, shift register and counters live in `morse_shifter`.

## Test plan
- Letter A (0), `tick` every 4 cycles, gap enabled → `morse_out` units 1,0,1,1,1 then 0,0,0; `done` pulses once after 8 ticks; `busy` is high throughout.
- Letter E (4) → a single high unit, then 3 low units, then `done`.
- With the gap feature compiled out, letter T (19) → 3 high units; `done` arrives the cycle after the 3rd tick.
- `letter`=27 with `start` → `busy` stays 0, `morse_out` stays 0, no `done`.
- Letter J, then `start` with letter E during the 5th unit → J completes unchanged (13 units); E is never sent.
- Letter J, `clear_b` pulsed low mid-unit 7 (asynchronous, between edges) → all outputs 0 immediately. A fresh A afterwards sends correctly. Also check that `tick` coincident with `start` does not advance the first unit.
